// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU controller: one 1-bit ALU slice stepped LSB first over WIDTH
// cycles per operation, with IDLE/RUN/DONE sequencing and registered results.
module bit_serial_alu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [2:0]       op_lat;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             bb;
  logic             g;
  logic             p;
  logic             s;
  logic             carry_nx;
  logic             rbit;
  logic             last;
  logic             ovf_c;
  logic             less_c;
  logic [WIDTH-1:0] res_c;

  // One-bit ALU slice on the current bit plus the final-result assembly
  always_comb begin
    bb       = b_lat[cnt] ^ op_lat[2];
    g        = a_lat[cnt] & bb;
    p        = a_lat[cnt] | bb;
    s        = a_lat[cnt] ^ bb ^ carry;
    carry_nx = g | (p & carry);
    case (op_lat[1:0])
      2'b00:   rbit = g;
      2'b01:   rbit = p;
      2'b10:   rbit = s;
      default: rbit = 1'b0;
    endcase
    last   = (cnt == CW'(WIDTH - 1));
    // carry into MSB is 'carry', carry out is 'carry_nx' on the last bit
    ovf_c  = op_lat[1] & (carry ^ carry_nx);
    less_c = s ^ carry ^ carry_nx;
    if (op_lat[1:0] == 2'b11) begin
      res_c = {{(WIDTH-1){1'b0}}, less_c};
    end else begin
      res_c = {rbit, work[WIDTH-1:1]};
    end
  end

  // Sequencer: latch on accept, shift one bit per RUN cycle, publish on DONE entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_lat    <= '0;
      b_lat    <= '0;
      op_lat   <= '0;
      work     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_lat  <= a;
            b_lat  <= b;
            op_lat <= op;
            cnt    <= '0;
            carry  <= op[2];
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          work  <= {rbit, work[WIDTH-1:1]};
          carry <= carry_nx;
          cnt   <= cnt + CW'(1);
          if (last) begin
            result   <= res_c;
            zero     <= (res_c == '0);
            overflow <= ovf_c;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl (WIDTH=32): directed operations push
// expected results; a monitor pops and compares on every done pulse.
module tb_bit_serial_alu_ctrl;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         o;
    string        nm;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   dq[$];

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
    .ready(ready), .done(done), .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // cycle counter, used to timestamp accepts and done pulses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: compare every done pulse against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      dq.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h with no pending operation", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_result"}, result, e.r);
        chk({e.nm, "_zero"}, W'(zero), W'(e.z));
        chk({e.nm, "_ovf"}, W'(overflow), W'(e.o));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=%b want 1", ready);
    end
  endtask

  // drive one accept; leaves start high when hold=1
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] opv,
                       input bit push, input logic [W-1:0] er, input logic ez, input logic eo,
                       input string nm, input bit hold, output int acc);
    exp_t e;
    wait_ready();
    a = av;
    b = bv;
    op = opv;
    start = 1'b1;
    if (push) begin
      e.r = er; e.z = ez; e.o = eo; e.nm = nm;
      exp_q.push_back(e);
    end
    @(negedge clk);
    acc = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int dc);
    int n;
    n = 0;
    while (dq.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (dq.size() == 0) begin
      total++;
      bad++;
      dc = -1;
      $display("FAIL %s_done_timeout: got no done want done", nm);
    end else begin
      dc = dq.pop_front();
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2:0] opv, input logic [W-1:0] er, input logic ez,
                        input logic eo);
    int acc;
    int dc;
    issue(av, bv, opv, 1'b1, er, ez, eo, nm, 1'b0, acc);
    wait_done(nm, dc);
    chk({nm, "_latency"}, W'(dc - acc), W);
  endtask

  initial begin
    int acc;
    int dc;
    int dc2;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", W'(ready), 32'd1);
    chk("rst_done", W'(done), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", W'(zero), 32'd1);
    chk("rst_ovf", W'(overflow), 32'd0);

    run_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_eq",   32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 1'b1, 1'b0);
    run_op("sub_neg",  32'h00000000, 32'h00000001, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("slt_lt",   32'hFFFFFFFB, 32'h00000003, 3'b111, 32'h00000001, 1'b0, 1'b0);
    run_op("slt_ovf",  32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1, 1'b1);
    run_op("and",      32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0, 1'b0);
    run_op("or",       32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0);
    run_op("andn",     32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h00F000F0, 1'b0, 1'b0);
    run_op("orn",      32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 32'hF0FFF0FF, 1'b0, 1'b0);
    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0);
    run_op("add_mn",   32'h80000000, 32'h80000000, 3'b010, 32'h00000000, 1'b1, 1'b1);

    // start pulsed mid-RUN with new operands must be ignored; inputs wiggle during RUN
    issue(32'd1, 32'd2, 3'b010, 1'b1, 32'd3, 1'b0, 1'b0, "ign", 1'b0, acc);
    repeat (5) @(negedge clk);
    chk("ign_ready_low", W'(ready), 32'd0);
    a = 32'd100; b = 32'd100; op = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEADBEEF; b = 32'h12345678; op = 3'b111;
    wait_done("ign", dc);
    chk("ign_latency", W'(dc - acc), W);
    repeat (4) @(negedge clk);
    chk("ign_no_second_done", W'(dq.size()), 32'd0);
    chk("hold_result", result, 32'd3);
    chk("hold_zero", W'(zero), 32'd0);

    // reset at bit cycle 10 aborts the operation with no done
    issue(32'd10, 32'd20, 3'b010, 1'b0, '0, 1'b0, 1'b0, "abort", 1'b0, acc);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("abort_ready", W'(ready), 32'd1);
    chk("abort_result", result, 32'h0);
    chk("abort_zero", W'(zero), 32'd1);
    chk("abort_done", W'(done), 32'd0);
    repeat (W + 5) @(negedge clk);
    chk("abort_no_done", W'(dq.size()), 32'd0);
    run_op("after_rst", 32'h00000010, 32'h00000020, 3'b010, 32'h00000030, 1'b0, 1'b0);

    // start held high: back-to-back operations every W+2 cycles
    issue(32'd6, 32'd7, 3'b010, 1'b1, 32'd13, 1'b0, 1'b0, "b2b1", 1'b1, acc);
    exp_q.push_back('{r: 32'd13, z: 1'b0, o: 1'b0, nm: "b2b2"});
    wait_done("b2b1", dc);
    chk("b2b1_latency", W'(dc - acc), W);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b2", dc2);
    chk("b2b_period", W'(dc2 - dc), W + 2);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", W'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
